// File: rtl/cv32e40x_pkg.sv
// Shared types for the sequential divider: opcode and FSM state encodings,
// plus small opcode-decode and two's-complement helpers.
package cv32e40x_pkg;

    typedef enum logic [1:0] {
        DIV_DIV  = 2'd0,
        DIV_DIVU = 2'd1,
        DIV_REM  = 2'd2,
        DIV_REMU = 2'd3
    } div_opcode_e;

    typedef enum logic [2:0] {
        DIV_IDLE    = 3'd0,
        DIV_CLZ     = 3'd1,
        DIV_SHIFT   = 3'd2,
        DIV_COMPUTE = 3'd3,
        DIV_FINISH  = 3'd4
    } div_state_e;

    function automatic logic op_is_signed(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_REM);
    endfunction

    function automatic logic op_is_div(input div_opcode_e op);
        return (op == DIV_DIV) || (op == DIV_DIVU);
    endfunction

    function automatic logic [31:0] negate32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

endpackage

// File: rtl/cv32e40x_div_seq.sv
// Iterative RV32M divider that borrows the ALU's leading-zero counter and
// funnel shifter to normalise the divisor before a restoring division loop.
module cv32e40x_div_seq
    import cv32e40x_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_valid_i,
    output logic        div_ready_o,
    input  logic [1:0]  div_op_i,
    input  logic [31:0] op_a_i,
    input  logic [31:0] op_b_i,
    input  logic        kill_i,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    input  logic        result_ready_i,
    output logic        alu_clz_en_o,
    output logic [31:0] alu_clz_data_o,
    input  logic [5:0]  alu_clz_result_i,
    output logic        alu_shift_en_o,
    output logic [5:0]  alu_shift_amt_o,
    output logic [31:0] alu_op_a_o,
    input  logic [31:0] alu_shifted_i
);

    div_state_e  state_q, state_d;
    div_opcode_e op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] abs_b_q, abs_b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dsh_q, dsh_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;

    logic        accept_s;
    logic        sgn_s;
    logic [32:0] diff_s;
    logic        ge_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;
    logic        clz_en_s;
    logic        shift_en_s;

    assign div_ready_o    = (state_q == DIV_IDLE);
    assign accept_s       = div_valid_i & div_ready_o & ~kill_i;
    assign sgn_s          = op_is_signed(div_opcode_e'(div_op_i));
    assign result_o       = result_q;
    assign result_valid_o = (state_q == DIV_FINISH);

    // One restoring step: the borrow of the 33-bit subtract is the compare.
    assign diff_s   = {1'b0, rem_q} - {1'b0, dsh_q};
    assign ge_s     = ~diff_s[32];
    assign rem_nx_s = ge_s ? diff_s[31:0] : rem_q;
    assign quo_nx_s = {quo_q[30:0], ge_s};

    // ALU enables are gated by kill so a flush frees the ALU in the same cycle.
    assign alu_clz_en_o   = clz_en_s & ~kill_i;
    assign alu_shift_en_o = shift_en_s & ~kill_i;

    // Next-state, datapath updates and ALU-borrow outputs.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        a_d             = a_q;
        abs_b_d         = abs_b_q;
        rem_d           = rem_q;
        dsh_d           = dsh_q;
        quo_d           = quo_q;
        result_d        = result_q;
        cnt_d           = cnt_q;
        q_neg_d         = q_neg_q;
        r_neg_d         = r_neg_q;
        clz_en_s        = 1'b0;
        shift_en_s      = 1'b0;
        alu_clz_data_o  = 32'd0;
        alu_shift_amt_o = 6'd0;
        alu_op_a_o      = 32'd0;

        case (state_q)
            DIV_IDLE: begin
                if (accept_s) begin
                    op_d    = div_opcode_e'(div_op_i);
                    a_d     = op_a_i;
                    abs_b_d = (sgn_s && op_b_i[31]) ? negate32(op_b_i) : op_b_i;
                    rem_d   = (sgn_s && op_a_i[31]) ? negate32(op_a_i) : op_a_i;
                    q_neg_d = sgn_s & (op_a_i[31] ^ op_b_i[31]) & (op_b_i != 32'd0);
                    r_neg_d = sgn_s & op_a_i[31];
                    state_d = DIV_CLZ;
                end else begin
                    state_d = DIV_IDLE;
                end
            end
            DIV_CLZ: begin
                clz_en_s       = 1'b1;
                alu_clz_data_o = abs_b_q;
                if (alu_clz_result_i == 6'd32) begin
                    result_d = op_is_div(op_q) ? 32'hFFFF_FFFF : a_q;
                    state_d  = DIV_FINISH;
                end else begin
                    cnt_d    = alu_clz_result_i[4:0];
                    state_d  = DIV_SHIFT;
                end
            end
            DIV_SHIFT: begin
                shift_en_s      = 1'b1;
                alu_op_a_o      = abs_b_q;
                alu_shift_amt_o = {1'b0, cnt_q};
                dsh_d           = alu_shifted_i;
                quo_d           = 32'd0;
                state_d         = DIV_COMPUTE;
            end
            DIV_COMPUTE: begin
                rem_d = rem_nx_s;
                quo_d = quo_nx_s;
                dsh_d = dsh_q >> 1;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    if (op_is_div(op_q)) begin
                        result_d = q_neg_q ? negate32(quo_nx_s) : quo_nx_s;
                    end else begin
                        result_d = r_neg_q ? negate32(rem_nx_s) : rem_nx_s;
                    end
                    state_d = DIV_FINISH;
                end else begin
                    state_d = DIV_COMPUTE;
                end
            end
            DIV_FINISH: begin
                if (result_ready_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d = DIV_FINISH;
                end
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase

        if (kill_i) begin
            state_d = DIV_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            op_q     <= DIV_DIV;
            a_q      <= 32'd0;
            abs_b_q  <= 32'd0;
            rem_q    <= 32'd0;
            dsh_q    <= 32'd0;
            quo_q    <= 32'd0;
            result_q <= 32'd0;
            cnt_q    <= 5'd0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            abs_b_q  <= abs_b_d;
            rem_q    <= rem_d;
            dsh_q    <= dsh_d;
            quo_q    <= quo_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
        end
    end

endmodule

// File: tb/tb_cv32e40x_div_seq.sv
// Randomised bench for cv32e40x_div_seq: models the borrowed ALU CLZ/shifter
// and checks every cycle against a plain-arithmetic RV32M reference.
module tb_cv32e40x_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_valid_i;
    logic        div_ready_o;
    logic [1:0]  div_op_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        kill_i;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic        result_ready_i;
    logic        alu_clz_en_o;
    logic [31:0] alu_clz_data_o;
    logic [5:0]  alu_clz_result_i;
    logic        alu_shift_en_o;
    logic [5:0]  alu_shift_amt_o;
    logic [31:0] alu_op_a_o;
    logic [31:0] alu_shifted_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one operation in flight at most.
    logic        m_active = 1'b0;
    int          m_cycles = 0;
    int          m_lat    = 0;
    logic [31:0] m_res    = 32'd0;

    always #5 clk = ~clk;

    cv32e40x_div_seq dut (
        .clk              (clk),
        .rst              (rst),
        .div_valid_i      (div_valid_i),
        .div_ready_o      (div_ready_o),
        .div_op_i         (div_op_i),
        .op_a_i           (op_a_i),
        .op_b_i           (op_b_i),
        .kill_i           (kill_i),
        .result_o         (result_o),
        .result_valid_o   (result_valid_o),
        .result_ready_i   (result_ready_i),
        .alu_clz_en_o     (alu_clz_en_o),
        .alu_clz_data_o   (alu_clz_data_o),
        .alu_clz_result_i (alu_clz_result_i),
        .alu_shift_en_o   (alu_shift_en_o),
        .alu_shift_amt_o  (alu_shift_amt_o),
        .alu_op_a_o       (alu_op_a_o),
        .alu_shifted_i    (alu_shifted_i)
    );

    function automatic logic [5:0] clz32(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) return 6'(31 - i);
        end
        return 6'd32;
    endfunction

    // Stand-in for the ALU's shared CLZ and shifter.
    always_comb begin
        alu_clz_result_i = clz32(alu_clz_data_o);
        alu_shifted_i    = alu_op_a_o << alu_shift_amt_o;
    end

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sgn, dv;
        logic [31:0] ma, mb, q, r;
        sgn = (op == 2'd0) || (op == 2'd2);
        dv  = (op == 2'd0) || (op == 2'd1);
        if (b == 32'd0) return dv ? 32'hFFFF_FFFF : a;
        ma = (sgn && a[31]) ? (32'd0 - a) : a;
        mb = (sgn && b[31]) ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sgn && a[31]) r = 32'd0 - r;
        return dv ? q : r;
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mb;
        mb = (((op == 2'd0) || (op == 2'd2)) && b[31]) ? (32'd0 - b) : b;
        if (mb == 32'd0) return 2;
        return 4 + int'(clz32(mb));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model advance on each active edge.
    always @(posedge clk) begin
        if (rst || kill_i) begin
            m_active <= 1'b0;
        end else if (!m_active && div_valid_i) begin
            m_active <= 1'b1;
            m_cycles <= 1;
            m_lat    <= ref_latency(div_op_i, op_b_i);
            m_res    <= ref_result(div_op_i, op_a_i, op_b_i);
        end else if (m_active) begin
            if (m_cycles >= m_lat) begin
                if (result_ready_i) m_active <= 1'b0;
            end else begin
                m_cycles <= m_cycles + 1;
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            chk("alu_en_exclusive", {31'd0, alu_clz_en_o & alu_shift_en_o}, 32'd0);
            if (kill_i) begin
                chk("kill_drops_alu_en", {30'd0, alu_clz_en_o, alu_shift_en_o}, 32'd0);
            end
            if (!m_active) begin
                chk("idle_ready", {31'd0, div_ready_o}, 32'd1);
                chk("idle_valid", {31'd0, result_valid_o}, 32'd0);
                chk("idle_alu_en", {30'd0, alu_clz_en_o, alu_shift_en_o}, 32'd0);
            end else begin
                chk("busy_ready", {31'd0, div_ready_o}, 32'd0);
                chk("valid_timing", {31'd0, result_valid_o}, {31'd0, m_cycles >= m_lat});
                if (m_cycles >= m_lat) chk("result", result_o, m_res);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (m_active && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) chk("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit pin, input logic [31:0] lit_res, input int lit_lat);
        int guard;
        wait_idle();
        div_valid_i = 1'b1;
        div_op_i    = op;
        op_a_i      = a;
        op_b_i      = b;
        step();
        div_valid_i = 1'b0;
        div_op_i    = 2'($urandom);
        op_a_i      = $urandom;
        op_b_i      = $urandom;
        if (pin) begin
            chk("model_latency", 32'(m_lat), 32'(lit_lat));
            chk("model_result", m_res, lit_res);
        end
        guard = 0;
        while (m_cycles < m_lat && guard < 100) begin
            step();
            guard++;
        end
        if (guard >= 100) chk("result_wait_timeout", 32'd1, 32'd0);
        if (pin) begin
            chk("lit_valid", {31'd0, result_valid_o}, 32'd1);
            chk("lit_result", result_o, lit_res);
        end
        repeat (hold) step();
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic [1:0]  op;
        rst            = 1'b1;
        div_valid_i    = 1'b0;
        div_op_i       = 2'd0;
        op_a_i         = 32'd0;
        op_b_i         = 32'd0;
        kill_i         = 1'b0;
        result_ready_i = 1'b0;
        repeat (3) step();
        chk("reset_result", result_o, 32'd0);
        chk("reset_valid", {31'd0, result_valid_o}, 32'd0);
        chk("reset_ready", {31'd0, div_ready_o}, 32'd1);
        chk("reset_alu", {26'd0, alu_clz_en_o, alu_shift_en_o, 4'd0} | alu_clz_data_o | alu_op_a_o
                         | {26'd0, alu_shift_amt_o}, 32'd0);
        rst = 1'b0;
        step();

        do_op(2'd1, 32'd100, 32'd7, 0, 1'b1, 32'd14, 33);
        do_op(2'd3, 32'd100, 32'd7, 2, 1'b1, 32'd2, 33);
        do_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, 1'b1, 32'hFFFF_FFFD, 34);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1, 1'b1, 32'hFFFF_FFFF, 34);
        do_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'h8000_0000, 35);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1, 32'd0, 35);
        do_op(2'd1, 32'd5, 32'd0, 0, 1'b1, 32'hFFFF_FFFF, 2);
        do_op(2'd2, 32'hFFFF_FFFB, 32'd0, 10, 1'b1, 32'hFFFF_FFFB, 2);

        // Flush in the middle of a long divide, then a fresh op.
        wait_idle();
        div_valid_i = 1'b1; div_op_i = 2'd1; op_a_i = 32'hFFFF_FFFF; op_b_i = 32'd1;
        step();
        div_valid_i = 1'b0;
        repeat (6) step();
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        do_op(2'd1, 32'd9, 32'd3, 0, 1'b1, 32'd3, 34);

        // Kill coinciding with a request in IDLE must win.
        wait_idle();
        div_valid_i = 1'b1; kill_i = 1'b1; op_a_i = 32'd50; op_b_i = 32'd5;
        step();
        div_valid_i = 1'b0; kill_i = 1'b0;
        step();
        chk("kill_beats_accept", {31'd0, div_ready_o}, 32'd1);

        // Reset mid-operation clears the held result.
        div_valid_i = 1'b1; div_op_i = 2'd0; op_a_i = 32'd1000; op_b_i = 32'd3;
        step();
        div_valid_i = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_clears_result", result_o, 32'd0);
        step();

        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom);
            a  = $urandom;
            case ($urandom_range(0, 4))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: b = 32'($urandom_range(1, 15));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            do_op(op, a, b, $urandom_range(0, 3), 1'b0, 32'd0, 0);
        end
        wait_idle();
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
